// File: rtl/tl_pkg.sv
// Shared state and light encodings for the two-road traffic-light controller.
package tl_pkg;

    localparam int CODE_W = 2;

    typedef enum logic [CODE_W-1:0] {
        S0 = 2'b00,
        S1 = 2'b01,
        S2 = 2'b10,
        S3 = 2'b11
    } state_t;

    localparam logic [CODE_W-1:0] GREEN  = 2'b00;
    localparam logic [CODE_W-1:0] YELLOW = 2'b01;
    localparam logic [CODE_W-1:0] RED    = 2'b10;

endpackage

// File: rtl/tl_dwell_cntr.sv
// Saturating dwell counter: synchronous clear wins over enable, never wraps.
module tl_dwell_cntr #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             clr,
    output logic [CNT_W-1:0] cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en && (cnt != CNT_MAX)) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/tl_dwell_fsm.sv
// Moore traffic-light FSM: sensor-gated greens with a max-green hand-over,
// fixed yellow dwell, light decode and a registered state-change pulse.
module tl_dwell_fsm
    import tl_pkg::*;
#(
    parameter int CNT_W   = 8,
    parameter int GRN_MIN = 10,
    parameter int GRN_MAX = 40,
    parameter int YEL_CYC = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    input  logic              ta,
    input  logic              tb,
    output logic [CODE_W-1:0] state,
    output logic [CODE_W-1:0] la,
    output logic [CODE_W-1:0] lb,
    output logic              chg
);

    // Thresholds are expressed as "last cnt value of the dwell" since cnt starts at 0.
    localparam logic [CNT_W-1:0] GMIN_LAST = CNT_W'(GRN_MIN - 1);
    localparam logic [CNT_W-1:0] GMAX_LAST = CNT_W'(GRN_MAX - 1);
    localparam logic [CNT_W-1:0] YEL_LAST  = CNT_W'(YEL_CYC - 1);

    state_t           state_q;
    state_t           state_d;
    logic             change;
    logic [CNT_W-1:0] cnt;

    tl_dwell_cntr #(
        .CNT_W(CNT_W)
    ) u_cntr (
        .clk  (clk),
        .reset(reset),
        .en   (en),
        .clr  (change),
        .cnt  (cnt)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S0;
            chg     <= 1'b0;
        end else begin
            state_q <= state_d;
            chg     <= change;
        end
    end

    always_comb begin
        state_d = state_q;
        if (en) begin
            case (state_q)
                S0: if ((!ta && cnt >= GMIN_LAST) || (tb && cnt >= GMAX_LAST)) state_d = S1;
                S1: if (cnt == YEL_LAST) state_d = S2;
                S2: if ((!tb && cnt >= GMIN_LAST) || (ta && cnt >= GMAX_LAST)) state_d = S3;
                S3: if (cnt == YEL_LAST) state_d = S0;
                default: state_d = S0;
            endcase
        end
    end

    // Next state only differs from current when en=1, so a frozen cycle yields chg=0.
    assign change = (state_d != state_q);

    always_comb begin
        la = RED;
        lb = RED;
        case (state_q)
            S0: la = GREEN;
            S1: la = YELLOW;
            S2: lb = GREEN;
            S3: lb = YELLOW;
            default: begin
                la = RED;
                lb = RED;
            end
        endcase
    end

    assign state = state_q;

endmodule
